// File: rtl/nt_stress_response_controller_if.sv
// Command/feedback bundle between the stress-response sequencer and its
// environment; slave is the sequencer side, master drives inputs and observes.
interface nt_stress_response_controller_if #(
  parameter int N = 7
);
  logic         stressor;
  logic         calm;
  logic [N-1:0] level;
  logic         inc;
  logic         dec;
  logic         fast;
  logic         setval;
  logic [2:0]   phase;
  logic         exhausted;
  logic [3:0]   exhaust_cnt;

  modport slave (
    input  stressor, calm, level,
    output inc, dec, fast, setval, phase, exhausted, exhaust_cnt
  );

  modport master (
    output stressor, calm, level,
    input  inc, dec, fast, setval, phase, exhausted, exhaust_cnt
  );
endinterface

// File: rtl/nt_stress_response_controller.sv
// Stress-response phase machine for the cortisol level resource: turns the
// stressor/calm pair into rate-limited inc/dec/fast/setval command pulses.
module nt_stress_response_controller #(
  parameter int N              = 7,
  parameter int TICK_DIV       = 4,
  parameter int ALARM_LEN      = 8,
  parameter int RESIST_MAX     = 32,
  parameter int HIGH_THRESH    = 96,
  parameter int RECOVER_THRESH = 16
) (
  input logic                          clk,
  input logic                          rst,
  nt_stress_response_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALARM   = 3'd1,
    RESIST  = 3'd2,
    RECOVER = 3'd3,
    EXHAUST = 3'd4
  } phase_t;

  localparam logic [7:0]   TICK_LAST   = 8'(TICK_DIV - 1);
  localparam logic [7:0]   ALARM_LAST  = 8'(ALARM_LEN - 1);
  localparam logic [7:0]   RESIST_LAST = 8'(RESIST_MAX - 1);
  localparam logic [N-1:0] HIGH_LVL    = N'(HIGH_THRESH);
  localparam logic [N-1:0] RECOVER_LVL = N'(RECOVER_THRESH);

  phase_t     phase_q, phase_d;
  logic [7:0] tick_cnt;
  logic [7:0] dwell;
  logic [3:0] exhaust_cnt;
  logic       tick;

  logic inc_p0, dec_p0, fast_p0, setval_p0, exh_entry_p0;
  logic inc_p1, dec_p1, fast_p1, setval_p1;

  assign tick = (tick_cnt == TICK_LAST);

  // Stage p0: next phase and candidate command, evaluated every cycle but
  // only committed on the tick edge.
  always_comb begin
    phase_d      = phase_q;
    inc_p0       = 1'b0;
    dec_p0       = 1'b0;
    fast_p0      = 1'b0;
    setval_p0    = 1'b0;
    exh_entry_p0 = 1'b0;
    case (phase_q)
      IDLE: begin
        if (bus.stressor)            phase_d = ALARM;
        else if (bus.level != '0)    dec_p0  = 1'b1;
      end
      ALARM: begin
        if (bus.level < HIGH_LVL) begin
          inc_p0  = 1'b1;
          fast_p0 = 1'b1;
        end
        if (dwell == ALARM_LAST)     phase_d = RESIST;
      end
      RESIST: begin
        if (!bus.stressor) begin
          phase_d = RECOVER;
        end else if (dwell == RESIST_LAST) begin
          setval_p0    = 1'b1;
          exh_entry_p0 = 1'b1;
          phase_d      = EXHAUST;
        end else if (bus.level < HIGH_LVL) begin
          inc_p0 = 1'b1;
        end
      end
      RECOVER: begin
        if (bus.stressor) begin
          phase_d = ALARM;
        end else if (bus.level <= RECOVER_LVL) begin
          phase_d = IDLE;
        end else begin
          dec_p0  = 1'b1;
          fast_p0 = bus.calm;
        end
      end
      EXHAUST: begin
        if (!bus.stressor && bus.calm) phase_d = RECOVER;
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       phase_q <= IDLE;
    else if (tick) phase_q <= phase_d;
  end

  // Stage p1: registered command pulses, prescaler, dwell and episode count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      dwell       <= '0;
      exhaust_cnt <= '0;
      inc_p1      <= 1'b0;
      dec_p1      <= 1'b0;
      fast_p1     <= 1'b0;
      setval_p1   <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 8'd1;
      inc_p1    <= tick & inc_p0;
      dec_p1    <= tick & dec_p0;
      fast_p1   <= tick & fast_p0;
      setval_p1 <= tick & setval_p0;
      if (tick) begin
        dwell <= (phase_d != phase_q) ? 8'd0 : dwell + 8'd1;
        if (exh_entry_p0 && exhaust_cnt != 4'd15)
          exhaust_cnt <= exhaust_cnt + 4'd1;
      end
    end
  end

  assign bus.inc         = inc_p1;
  assign bus.dec         = dec_p1;
  assign bus.fast        = fast_p1;
  assign bus.setval      = setval_p1;
  assign bus.phase       = phase_q;
  assign bus.exhausted   = (phase_q == EXHAUST);
  assign bus.exhaust_cnt = exhaust_cnt;

endmodule

// File: tb/tb_nt_stress_response_controller.sv
// Directed bench for the stress-response sequencer with hand-computed
// expectations; cycle 0 is the first cycle after reset release.
module tb_nt_stress_response_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nt_stress_response_controller_if #(.N(7)) bus();

  nt_stress_response_controller #(
    .N(7), .TICK_DIV(4), .ALARM_LEN(8), .RESIST_MAX(32),
    .HIGH_THRESH(96), .RECOVER_THRESH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int cur        = 0;
  int n_is, n_if, n_ds, n_df, n_set, n_viol;
  int guard;
  int timeouts   = 0;

  function automatic logic [3:0] cmds();
    return {bus.inc, bus.dec, bus.fast, bus.setval};
  endfunction

  function automatic logic [47:0] stats();
    return {8'(n_is), 8'(n_if), 8'(n_ds), 8'(n_df), 8'(n_set), 8'(n_viol)};
  endfunction

  task automatic clr();
    n_is = 0; n_if = 0; n_ds = 0; n_df = 0; n_set = 0; n_viol = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and tally command pulses; any pulse off the tick
  // grid, overlapping commands or a lone fast counts as a violation.
  task automatic cyc();
    @(posedge clk);
    #1;
    cur++;
    if (bus.inc &&  bus.fast) n_if++;
    if (bus.inc && !bus.fast) n_is++;
    if (bus.dec &&  bus.fast) n_df++;
    if (bus.dec && !bus.fast) n_ds++;
    if (bus.setval)           n_set++;
    if ((int'(bus.inc) + int'(bus.dec) + int'(bus.setval)) > 1 ||
        (bus.fast && !bus.inc && !bus.dec) ||
        (cmds() != 4'd0 && (cur % 4) != 0))
      n_viol++;
  endtask

  task automatic run_to(input int t);
    while (cur < t) cyc();
  endtask

  task automatic do_reset(input logic s, input logic c, input logic [6:0] l);
    bus.stressor = s;
    bus.calm     = c;
    bus.level    = l;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = 0;
    clr();
  endtask

  initial begin
    bus.stressor = 1'b0;
    bus.calm     = 1'b0;
    bus.level    = 7'd0;

    // Reset state and quiet IDLE
    do_reset(1'b0, 1'b0, 7'd0);
    chk("rst_state", {bus.phase, cmds(), bus.exhaust_cnt, bus.exhausted}, 64'd0);
    run_to(40);
    chk("idle_l0_stats", stats(), 48'd0);
    chk("idle_l0_phase", bus.phase, 3'd0);

    // IDLE with level 5: slow dec every tick, first at cycle 4
    do_reset(1'b0, 1'b0, 7'd5);
    run_to(3);
    chk("idle_l5_quiet_pre4", stats(), 48'd0);
    cyc();
    chk("idle_l5_dec_c4", cmds(), 4'b0100);
    run_to(40);
    chk("idle_l5_stats", stats(), {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0});

    // ALARM timing: 8 inc+fast pulses at 8..36, RESIST after 9th tick
    do_reset(1'b1, 1'b0, 7'd0);
    run_to(3);
    chk("alarm_phase_c3", bus.phase, 3'd0);
    cyc();
    chk("alarm_phase_c4", {bus.phase, cmds()}, {3'd1, 4'b0000});
    run_to(8);
    chk("alarm_inc_c8", cmds(), 4'b1010);
    run_to(35);
    chk("alarm_phase_c35", bus.phase, 3'd1);
    cyc();
    chk("resist_phase_c36", {bus.phase, cmds()}, {3'd2, 4'b1010});
    chk("alarm_stats", stats(), {8'd0, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0});

    // ALARM with level at HIGH_THRESH suppresses inc; 95 resumes it
    do_reset(1'b1, 1'b0, 7'd96);
    run_to(20);
    chk("alarm_high_stats", stats(), 48'd0);
    chk("alarm_high_phase", bus.phase, 3'd1);
    bus.level = 7'd95;
    run_to(23);
    chk("alarm_95_pre", cmds(), 4'b0000);
    cyc();
    chk("alarm_95_inc_c24", cmds(), 4'b1010);

    // Sustained stressor to EXHAUST, hold, then calm to RECOVER
    do_reset(1'b1, 1'b0, 7'd0);
    run_to(163);
    chk("resist_c163_phase", bus.phase, 3'd2);
    chk("resist_stats", stats(), {8'd31, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0});
    cyc();
    chk("exhaust_entry_c164",
        {bus.phase, cmds(), bus.exhausted, bus.exhaust_cnt},
        {3'd4, 4'b0001, 1'b1, 4'd1});
    bus.stressor = 1'b0;
    clr();
    run_to(182);
    chk("exhaust_hold", {bus.phase, bus.exhausted, stats()}, {3'd4, 1'b1, 48'd0});
    bus.calm = 1'b1;
    run_to(184);
    chk("exhaust_to_recover", {bus.phase, bus.exhausted, cmds()}, {3'd3, 1'b0, 4'b0000});

    // RESIST at level 40 -> RECOVER decs (fast tracks calm) -> IDLE at 16
    do_reset(1'b1, 1'b0, 7'd40);
    run_to(44);
    chk("rec_resist_c44", {bus.phase, cmds()}, {3'd2, 4'b1000});
    bus.stressor = 1'b0;
    run_to(48);
    chk("rec_enter_c48", {bus.phase, cmds()}, {3'd3, 4'b0000});
    run_to(52);
    chk("rec_dec_slow_c52", cmds(), 4'b0100);
    bus.calm = 1'b1;
    run_to(56);
    chk("rec_dec_fast_c56", cmds(), 4'b0110);
    bus.calm = 1'b0;
    run_to(60);
    chk("rec_dec_slow_c60", cmds(), 4'b0100);
    bus.level = 7'd16;
    run_to(64);
    chk("rec_to_idle_c64", {bus.phase, cmds()}, {3'd0, 4'b0000});
    chk("rec_violations", 8'(n_viol), 8'd0);

    // Re-trigger from RECOVER
    do_reset(1'b1, 1'b0, 7'd40);
    run_to(44);
    bus.stressor = 1'b0;
    run_to(48);
    bus.stressor = 1'b1;
    run_to(52);
    chk("rec_retrigger_c52", {bus.phase, cmds()}, {3'd1, 4'b0000});

    // 16 exhaustion episodes; counter saturates at 15
    do_reset(1'b1, 1'b0, 7'd0);
    for (int e = 1; e <= 16; e++) begin
      bus.stressor = 1'b1;
      bus.calm     = 1'b0;
      guard = 0;
      while (!bus.exhausted && guard < 400) begin cyc(); guard++; end
      if (guard >= 400) timeouts++;
      bus.stressor = 1'b0;
      bus.calm     = 1'b1;
      guard = 0;
      while (bus.phase != 3'd3 && guard < 20) begin cyc(); guard++; end
      if (guard >= 20) timeouts++;
      if (e == 15) chk("exh_cnt_15", bus.exhaust_cnt, 4'd15);
      bus.stressor = 1'b1;
      bus.calm     = 1'b0;
      guard = 0;
      while (bus.phase != 3'd1 && guard < 20) begin cyc(); guard++; end
      if (guard >= 20) timeouts++;
    end
    chk("exh_timeouts", timeouts, 0);
    chk("exh_cnt_sat", {bus.phase, bus.exhaust_cnt}, {3'd1, 4'd15});

    // Reset on a tick edge mid-ALARM
    repeat (5) cyc();
    while ((cur % 4) != 3) cyc();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_state", {bus.phase, cmds(), bus.exhaust_cnt}, 64'd0);
    rst = 1'b0;
    cur = 0;
    clr();
    bus.stressor = 1'b0;
    bus.level    = 7'd5;
    run_to(3);
    chk("midrst_quiet", stats(), 48'd0);
    cyc();
    chk("midrst_first_dec_c4", {bus.phase, cmds()}, {3'd0, 4'b0100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
